// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared CPU definitions used by the instruction fetch sequencer:
//   the fetch FSM state encoding, the sequential PC increment, and the
//   default exception entry vector.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding or about to be issued
    ST_VALID = 2'd1,  // instruction buffered, waiting for decode
    ST_DRAIN = 2'd2   // stale request in flight, response will be dropped
  } fetch_state_e;

  localparam logic [31:0] PC_STEP_DEFAULT    = 32'd4;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0080;

endpackage : fetch_sequencer_pkg

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction fetch control for the multicycle core. Sole writer of the PC
//   register: applies sequential increments, branch/jump redirects and
//   exception entry. Runs the req/ack handshake with instruction memory and
//   buffers the fetched word until decode takes it.
//
// Ports
//   clk, reset     clock; synchronous active-high reset
//   pc             current PC (PC register output)
//   pc_next        PC register data input            (combinational)
//   pc_write       PC register write enable          (combinational)
//   imem_req       instruction memory request        (combinational)
//   imem_addr      instruction memory address        (combinational)
//   imem_ack       memory returns imem_rdata this cycle
//   imem_rdata     fetched instruction word
//   instr          buffered instruction              (registered)
//   instr_pc       address of instr                  (registered)
//   instr_valid    instr is valid                    (registered)
//   instr_ready    decode accepts instr this cycle
//   redirect       taken branch/jump, target on redirect_pc
//   exc            exception, PC goes to EXC_VECTOR (beats redirect)
// -----------------------------------------------------------------------------
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc
);

  fetch_state_e state_q;
  logic         pending_q;
  logic [31:0]  addr_q;
  logic [31:0]  instr_q;
  logic [31:0]  instr_pc_q;
  logic         instr_valid_q;

  logic         flush;     // exc or redirect this cycle
  logic [31:0]  flush_pc;  // target of the flush

  assign flush    = exc | redirect;
  assign flush_pc = exc ? EXC_VECTOR : redirect_pc;

  // ---------------------------------------------------------------------------
  // Combinational handshake and PC-register controls. The first FETCH cycle
  // addresses memory straight from pc; afterwards the latched address is held
  // so it stays stable until the ack even if pc changes underneath.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    pc_next   = 32'd0;
    pc_write  = 1'b0;
    imem_req  = 1'b0;
    imem_addr = 32'd0;

    if (!reset) begin
      imem_addr = addr_q;
      unique case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (!pending_q) imem_addr = pc;
          if (imem_ack && !flush) begin
            pc_write = 1'b1;
            pc_next  = imem_addr + PC_STEP;  // wraps modulo 2^32
          end
        end
        ST_DRAIN: begin
          imem_req = 1'b1;
        end
        default: ;
      endcase

      // Exception/redirect overrides any increment in the same cycle.
      if (flush) begin
        pc_write = 1'b1;
        pc_next  = flush_pc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered instruction buffer.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and ordering between them is irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_FETCH;
      pending_q     <= 1'b0;
      addr_q        <= 32'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= 32'd0;
      instr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          addr_q <= imem_addr;
          if (imem_ack) begin
            pending_q <= 1'b0;
            if (flush) begin
              // Response belongs to the wrong path: drop it, refetch.
              state_q <= ST_FETCH;
            end else begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= imem_addr;
              instr_valid_q <= 1'b1;
              state_q       <= ST_VALID;
            end
          end else begin
            pending_q <= 1'b1;
            // Request is already on the bus; wait it out and drop the data.
            if (flush) state_q <= ST_DRAIN;
          end
        end

        ST_VALID: begin
          // Ack here has no matching request and is ignored.
          if (flush || instr_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end

        ST_DRAIN: begin
          if (imem_ack) begin
            pending_q <= 1'b0;
            state_q   <= ST_FETCH;
          end
        end

        default: begin
          pending_q     <= 1'b0;
          instr_valid_q <= 1'b0;
          state_q       <= ST_FETCH;
        end
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Includes a behavioural PC register
//   (reset to 0, loads pc_next on pc_write) since the sequencer drives it.
//   Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_next     (pc_next),
    .pc_write    (pc_write),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .exc         (exc)
  );

  // External PC register.
  always @(posedge clk) begin
    if (reset)         pc <= 32'd0;
    else if (pc_write) pc <= pc_next;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'd0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    exc         = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_req",    imem_req,    0);
    check("rst_pcw",    pc_write,    0);
    check("rst_pcnext", pc_next,     0);
    check("rst_addr",   imem_addr,   0);
    check("rst_valid",  instr_valid, 0);
    check("rst_instr",  instr,       0);
    check("rst_ipc",    instr_pc,    0);
    check("rst_pc",     pc,          0);

    // Basic fetch, zero-wait
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h2002_000A;
    #1;
    check("bf_req",    imem_req,  1);
    check("bf_addr",   imem_addr, 0);
    check("bf_pcw",    pc_write,  1);
    check("bf_pcnext", pc_next,   4);
    tick();
    imem_ack = 1'b0;
    #1;
    check("bf_valid", instr_valid, 1);
    check("bf_instr", instr,       32'h2002_000A);
    check("bf_ipc",   instr_pc,    0);
    check("bf_pc",    pc,          4);
    check("bf_req_v", imem_req,    0);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check("bp_instr", instr,       32'h2002_000A);
      check("bp_valid", instr_valid, 1);
      check("bp_req",   imem_req,    0);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    #1;
    check("bp_req_next",  imem_req,    1);
    check("bp_addr_next", imem_addr,   4);
    check("bp_valid_off", instr_valid, 0);

    // Fetch address 4, then redirect while VALID
    imem_ack   = 1'b1;
    imem_rdata = 32'h1111_1111;
    tick();
    imem_ack = 1'b0;
    #1;
    check("f4_ipc", instr_pc, 4);
    check("f4_pc",  pc,       8);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    #1;
    check("rv_pcw",    pc_write, 1);
    check("rv_pcnext", pc_next,  32'h100);
    tick();
    redirect = 1'b0;
    #1;
    check("rv_valid", instr_valid, 0);
    check("rv_addr",  imem_addr,   32'h100);
    check("rv_req",   imem_req,    1);

    // Redirect on the first FETCH cycle -> DRAIN
    redirect    = 1'b1;
    redirect_pc = 32'h8;
    #1;
    check("rf_pcnext", pc_next,   8);
    check("rf_addr",   imem_addr, 32'h100);
    tick();
    redirect = 1'b0;
    #1;
    check("rf_drain_req",  imem_req,  1);
    check("rf_drain_addr", imem_addr, 32'h100);
    check("rf_drain_pcw",  pc_write,  0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check("rf_ack_pcw", pc_write, 0);
    tick();
    imem_ack = 1'b0;
    #1;
    check("rf_valid", instr_valid, 0);
    check("rf_instr", instr,       32'h1111_1111);
    check("rf_addr8", imem_addr,   8);

    // Redirect while pending: request at 8, redirect on cycle 1, ack on cycle 3
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("rp_addr1",   imem_addr, 8);
    check("rp_pcw",     pc_write,  1);
    check("rp_pcnext",  pc_next,   32'h40);
    tick();
    redirect = 1'b0;
    #1;
    check("rp_addr2", imem_addr, 8);
    check("rp_req2",  imem_req,  1);
    check("rp_pcw2",  pc_write,  0);
    check("rp_pc",    pc,        32'h40);
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    #1;
    check("rp_addr3", imem_addr, 8);
    check("rp_pcw3",  pc_write,  0);
    tick();
    imem_ack = 1'b0;
    #1;
    check("rp_valid", instr_valid, 0);
    check("rp_addr",  imem_addr,   32'h40);
    check("rp_req",   imem_req,    1);

    // Exception and redirect together with an ack
    imem_ack    = 1'b1;
    imem_rdata  = 32'hCAFE_F00D;
    exc         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    #1;
    check("ex_pcnext", pc_next,  32'h80);
    check("ex_pcw",    pc_write, 1);
    tick();
    imem_ack = 1'b0;
    exc      = 1'b0;
    redirect = 1'b0;
    #1;
    check("ex_valid", instr_valid, 0);
    check("ex_addr",  imem_addr,   32'h80);
    check("ex_req",   imem_req,    1);

    // Reset mid-request, late ack while in reset
    tick();
    reset = 1'b1;
    tick();
    imem_ack   = 1'b1;
    imem_rdata = 32'h7777_7777;
    #1;
    check("mr_req",   imem_req,    0);
    check("mr_addr",  imem_addr,   0);
    check("mr_pcw",   pc_write,    0);
    check("mr_valid", instr_valid, 0);
    check("mr_pc",    pc,          0);
    tick();
    reset    = 1'b0;
    imem_ack = 1'b0;
    #1;
    check("mr_valid2", instr_valid, 0);
    check("mr_instr",  instr,       0);
    check("mr_req2",   imem_req,    1);
    check("mr_addr2",  imem_addr,   0);

    // PC wrap: redirect with same-cycle ack, then fetch at 0xFFFFFFFC
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    imem_rdata = 32'h0BAD_CAFE;
    #1;
    check("wr_valid0", instr_valid, 0);
    check("wr_addr",   imem_addr,   32'hFFFF_FFFC);
    check("wr_pcnext", pc_next,     0);
    check("wr_pcw",    pc_write,    1);
    tick();
    #1;
    check("wr_valid", instr_valid, 1);
    check("wr_ipc",   instr_pc,    32'hFFFF_FFFC);
    check("wr_pc",    pc,          0);

    // Ack while VALID is ignored
    imem_rdata = 32'h5555_5555;
    #1;
    check("iv_pcw", pc_write, 0);
    tick();
    imem_ack = 1'b0;
    #1;
    check("iv_instr", instr,       32'h0BAD_CAFE);
    check("iv_valid", instr_valid, 1);
    check("iv_pc",    pc,          0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_fetch_sequencer

// File: doc/fetch_sequencer.md
# fetch_sequencer

Controls instruction fetch for the multicycle CPU core. It drives the PC register's next-address and write-enable inputs, runs the request/acknowledge handshake with instruction memory, and holds each fetched instruction until decode accepts it. Branch/jump redirects and exception entry are applied here, so the PC register has exactly one writer.

## Interface

- `EXC_VECTOR`, default 32'h0000_0080: PC loaded on exception entry.
- `PC_STEP`, default 32'd4: sequential PC increment in bytes.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; clock `clk`.
- `pc`  in  32  current PC, taken from the PC register output.
- `pc_next`  out  32  next PC, drives the PC register data input.
- `pc_write`  out  1  PC register write enable.
- `imem_req`  out  1  instruction memory request.
- `imem_addr`  out  32  fetch address.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  buffered instruction for decode.
- `instr_pc`  out  32  address of `instr`.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  decode accepts `instr` this cycle.
- `redirect`  in  1  taken branch or jump.
- `redirect_pc`  in  32  redirect target.
- `exc`  in  1  exception; load `EXC_VECTOR`.

## Operation

- **States:** FETCH, VALID, DRAIN. The state after reset is FETCH with no request pending.
- **FETCH:**
  - `imem_req`=1.
  - On the first cycle, `imem_addr` = `pc`, latched into `addr_q`, and `pending` is set. On later cycles, `imem_addr` = `addr_q`; the address is held stable until ack.
  - On `imem_ack`: `instr` <= `imem_rdata`, `instr_pc` <= current `imem_addr`; `pc_write`=1; `pc_next` = `imem_addr` + `PC_STEP` (mod 2^32, wrap to 0); `pending` clears; go to VALID.
- **VALID:**
  - `instr_valid`=1, `imem_req`=0.
  - `instr`/`instr_pc` stay stable while `instr_ready`=0.
  - When `instr_valid`&&`instr_ready`, go to FETCH.
- **DRAIN:**
  - A request was outstanding when a redirect occurred. `imem_req` stays 1 and `imem_addr` = `addr_q`.
  - On ack, the data is discarded, `instr` is not updated, `pc_write`=0, and the state goes to FETCH.
- **Redirect priority** (every state): `exc` > `redirect` > sequential.
  - If `exc` or `redirect` is asserted, `pc_write`=1 and `pc_next` = `EXC_VECTOR` or `redirect_pc`; this overrides an increment in the same cycle.
  - In VALID, the buffered instruction is dropped (`instr_valid`=0 next cycle) and the state goes to FETCH.
  - In FETCH with `pending`=1 and no ack, go to DRAIN.
  - In FETCH with ack in the same cycle, the data is discarded and the state goes to FETCH.
  - In FETCH on the first cycle (`pending`=0), the request is issued and the state goes to DRAIN.
  - In DRAIN, the PC is rewritten and the state stays DRAIN; if an ack arrives in the same cycle, go to FETCH.
- `imem_ack` while no request is outstanding is ignored.
- **Reset:** has priority over everything. Outputs become `pc_write`=0, `pc_next`=0, `imem_req`=0, `imem_addr`=0, `instr`=0, `instr_pc`=0, `instr_valid`=0, `pending`=0, state FETCH. The PC register resets to 0 on the same edge. A reset mid-request abandons the request, and an ack arriving after reset is ignored.

## Timing

- `pc_next`, `pc_write` and `imem_req` are combinational from state, `pending` and inputs. `instr`, `instr_pc`, `instr_valid` and `addr_q` are registered.
- **Fetch latency:**
  - The request is issued in the first FETCH cycle.
  - With a same-cycle ack, `instr_valid`=1 on the next cycle.
  - With an ack k cycles later, `instr_valid` rises k+1 cycles after the first FETCH cycle.
- **Throughput:** at most one instruction per 2 cycles (FETCH+VALID) with zero-wait memory.
- The `pc_write` increment pulse coincides with the ack cycle, so `pc` is already advanced when `instr_valid` rises.
- A redirect is visible on `pc` one cycle later. The next request uses the new `pc` (directly from FETCH, or after DRAIN completes).

## Structure

- The shared CPU package holds the state encoding constants (FETCH=2'd0, VALID=2'd1, DRAIN=2'd2), `PC_STEP` and the default `EXC_VECTOR`.
- The block is a single module. It instantiates no sub-module; it sits beside the existing PC register in the core top level and drives that register's data input and write enable.

## Test plan

- **Basic fetch:** reset, then zero-wait memory returning 32'h2002000A → on the ack cycle `pc_write`=1 with `pc_next`=4; the next cycle has `instr_valid`=1, `instr`=32'h2002000A, `instr_pc`=0.
- **Backpressure:** hold `instr_ready`=0 for 5 cycles → `instr` stable, `imem_req`=0 throughout; the request for address 4 is issued the cycle after ready.
- **Redirect in VALID:** `redirect_pc`=32'h100 → `pc_write`=1, `pc_next`=32'h100; `instr_valid`=0 next cycle; the next `imem_addr`=32'h100.
- **Redirect while pending:** ack delayed 3 cycles on address 8, redirect to 32'h40 on cycle 1 → DRAIN with `imem_addr` held at 8; the returned data is not presented; the next request is to 32'h40.
- **Simultaneous exception and redirect:** `exc` and `redirect` asserted on the same cycle as an ack → `pc_next`=32'h80, the fetched word is discarded, the next request is to 32'h80.
- **Reset mid-request:** assert `reset` while a request is pending → all outputs 0 next cycle; a late ack leaves `instr_valid`=0; the first request is to address 0.
